kpyd_scanner: RTL

Matrix-keypad scanner that sits directly upstream of the keypad debouncer. It drives active-low column strobes one at a time and samples the raw row lines through a 2-flop synchronizer. Each complete scan frame is reduced to a single "any key pressed" level and a key code. press_o connects to the debouncer's press_i; key_o and multi_o go to the keypad decode logic.

---
 rtl/kpyd_pkg.sv | 35 +++
 rtl/kpyd_sync.sv | 26 ++
 rtl/kpyd_scanner.sv | 119 +++++++++++
 3 files changed

// File: rtl/kpyd_pkg.sv
// rtl/kpyd_pkg.sv - shared types, defaults and encode helpers for the keypad scanner
package kpyd_pkg;

  localparam int unsigned KPYD_ROWS_DEF   = 4;
  localparam int unsigned KPYD_COLS_DEF   = 4;
  localparam int unsigned KPYD_SETTLE_DEF = 16;

  // Widest key matrix the encode helpers accept; callers zero-extend into it.
  localparam int unsigned KPYD_MAX_KEYS = 256;

  typedef enum logic [1:0] {
    ST_SETTLE,
    ST_SAMPLE,
    ST_COMMIT
  } kpyd_state_e;

  function automatic int unsigned key_width(input int unsigned rows, input int unsigned cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction

  function automatic int lowest_set(input logic [KPYD_MAX_KEYS-1:0] v);
    int idx;
    idx = 0;
    for (int i = KPYD_MAX_KEYS - 1; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

  // popcount(v) > 1 is equivalent to v still being non-zero once its lowest set bit is cleared
  function automatic logic more_than_one(input logic [KPYD_MAX_KEYS-1:0] v);
    return |(v & (v - {{(KPYD_MAX_KEYS-1){1'b0}}, 1'b1}));
  endfunction

endpackage

// File: rtl/kpyd_sync.sv
// rtl/kpyd_sync.sv - parameterized-width 2-flop synchronizer, resets to all ones
module kpyd_sync #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/kpyd_scanner.sv
// rtl/kpyd_scanner.sv - column-strobing matrix keypad scanner with per-frame key summary
module kpyd_scanner
  import kpyd_pkg::*;
#(
  parameter int unsigned rows_p          = KPYD_ROWS_DEF,
  parameter int unsigned cols_p          = KPYD_COLS_DEF,
  parameter int unsigned settle_cycles_p = KPYD_SETTLE_DEF
) (
  input  logic                                    clk_i,
  input  logic                                    reset_n_i,
  input  logic [rows_p-1:0]                       row_i,
  output logic [cols_p-1:0]                       col_o,
  output logic                                    press_o,
  output logic [key_width(rows_p, cols_p)-1:0]    key_o,
  output logic                                    multi_o,
  output logic                                    frame_o
);

  localparam int unsigned NK = rows_p * cols_p;
  localparam int unsigned KW = key_width(rows_p, cols_p);
  localparam int unsigned CW = (cols_p > 1) ? $clog2(cols_p) : 1;
  localparam int unsigned SW = (settle_cycles_p > 1) ? $clog2(settle_cycles_p) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(cols_p - 1);
  localparam logic [SW-1:0] CNT_LOAD = SW'(settle_cycles_p - 1);

  logic [rows_p-1:0] row_s;

  kpyd_sync #(.WIDTH(rows_p)) u_sync (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .d_i       (row_i),
    .q_o       (row_s)
  );

  kpyd_state_e       state_q, state_d;
  logic [SW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     col_idx_q, col_idx_d;
  logic [NK-1:0]     acc_q, acc_d;
  logic [cols_p-1:0] col_q, col_d;
  logic              press_q, press_d;
  logic [KW-1:0]     key_q, key_d;
  logic              multi_q, multi_d;
  logic              frame_q, frame_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    col_idx_d = col_idx_q;
    acc_d     = acc_q;
    press_d   = press_q;
    key_d     = key_q;
    multi_d   = multi_q;
    frame_d   = 1'b0;

    case (state_q)
      ST_SETTLE: begin
        if (cnt_q == '0) state_d = ST_SAMPLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_SAMPLE: begin
        acc_d[int'(col_idx_q) * rows_p +: rows_p] = ~row_s;
        if (col_idx_q == COL_LAST) begin
          state_d = ST_COMMIT;
        end else begin
          col_idx_d = col_idx_q + 1'b1;
          cnt_d     = CNT_LOAD;
          state_d   = ST_SETTLE;
        end
      end
      ST_COMMIT: begin
        press_d = |acc_q;
        if (|acc_q) key_d = KW'(lowest_set(KPYD_MAX_KEYS'(acc_q)));
        multi_d   = more_than_one(KPYD_MAX_KEYS'(acc_q));
        frame_d   = 1'b1;
        acc_d     = '0;
        col_idx_d = '0;
        cnt_d     = CNT_LOAD;
        state_d   = ST_SETTLE;
      end
      default: state_d = ST_SETTLE;
    endcase

    // Strobe is registered from the next state so it tracks the FSM without a decode glitch.
    if (state_d == ST_COMMIT) col_d = '1;
    else                      col_d = ~({{(cols_p-1){1'b0}}, 1'b1} << col_idx_d);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= ST_SETTLE;
      cnt_q     <= CNT_LOAD;
      col_idx_q <= '0;
      acc_q     <= '0;
      col_q     <= '1;
      press_q   <= 1'b0;
      key_q     <= '0;
      multi_q   <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      col_idx_q <= col_idx_d;
      acc_q     <= acc_d;
      col_q     <= col_d;
      press_q   <= press_d;
      key_q     <= key_d;
      multi_q   <= multi_d;
      frame_q   <= frame_d;
    end
  end

  assign col_o   = col_q;
  assign press_o = press_q;
  assign key_o   = key_q;
  assign multi_o = multi_q;
  assign frame_o = frame_q;

endmodule
